adder_stim_checker: RTL and testbench
=====================================

ADDER_STIM_CHECKER -- requirements
Module: adder_stim_checker

Interface
REQ-001 Parameter LATENCY, default 2, meaning: DUT cycles from operand on ports to result on ports; legal range 1..4.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 start  input  1  one-cycle request to begin an exhaustive sweep.
REQ-005 A  output  4  operand A driven to adder DUT.
REQ-006 B  output  4  operand B driven to adder DUT.
REQ-007 Cin  output  1  carry-in driven to adder DUT.
REQ-008 Sum  input  4  DUT sum result.
REQ-009 Cout  input  1  DUT carry-out result.
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  high (level) in DONE.
REQ-012 err_count  output  10  mismatching results in current/last sweep.
REQ-013 pass  output  1  done AND err_count==0.

Function
REQ-014 FSM states IDLE, RUN, DRAIN, DONE; all outputs registered.
REQ-015 IDLE: start -> RUN; vector index v (9-bit) cleared to 0, err_count cleared.
REQ-016 RUN: each cycle present vector v as A=v[3:0], B=v[7:4], Cin=v[8], then v increments; after v=511 presented, -> DRAIN.
REQ-017 A vector presented in cycle n SHALL be checked against Sum/Cout sampled at end of cycle n+LATENCY.
REQ-018 Expected value = {Cout,Sum} = A+B+Cin, 5-bit unsigned, held in a LATENCY-deep pipeline with per-stage valid bit.
REQ-019 Mismatch on a valid stage increments err_count by 1; err_count saturates at 1023 (unreachable in one sweep, still required).
REQ-020 DRAIN: lasts exactly LATENCY cycles, no new vectors (A, B, Cin hold last value, valid=0 entering pipeline); then -> DONE.
REQ-021 DONE: done=1, err_count frozen; start -> RUN with v and err_count cleared, same cycle semantics as from IDLE.
REQ-022 start ignored while busy.
REQ-023 Total sweep: start sampled at edge t, first vector on ports after edge t, done rises after edge t+512+LATENCY.
REQ-024 Sum/Cout ignored whenever no valid stage is due.

Reset
REQ-025 rst_n=0 at a clock edge: state IDLE, A=B=0, Cin=0, busy=0, done=0, pass=0, err_count=0, pipeline valids cleared.
REQ-026 Reset mid-sweep aborts with no residual check; results of in-flight vectors discarded.
REQ-027 Reset dominates start in the same cycle.

Configuration
REQ-028 Macro ADDER_CHECK_FIRST_FAIL_EN defined: extra outputs first_fail_vec (9 bits, v of first mismatch) and first_fail_got (5 bits, {Cout,Sum} received), captured once per sweep, cleared to 0 by reset and at sweep start, and a 1-bit fail_seen flag.
REQ-029 Macro not defined: those ports and registers absent; all other behaviour identical.

Verification
REQ-030 Correct LATENCY=2 adder attached, start pulse -> busy for 514 cycles, done=1, err_count=0, pass=1.
REQ-031 DUT with Sum bit 0 stuck at 0 -> err_count=256, pass=0; with FIRST_FAIL_EN first_fail_vec=1, first_fail_got=5'b00000.
REQ-032 DUT ignoring Cin (Cin treated 0) -> err_count=256; with FIRST_FAIL_EN first_fail_vec=256.
REQ-033 rst_n low for one cycle at vector 100 -> IDLE, all outputs zero, no err_count change afterward; new start sweeps cleanly to pass=1.
REQ-034 start re-pulsed during RUN and in DONE -> ignored in RUN; in DONE new sweep begins, err_count cleared next cycle.
REQ-035 LATENCY=2 checker on a LATENCY=1 DUT -> err_count nonzero, pass=0.

Source files
------------

// File: rtl/adder_stim_checker.sv
// Exhaustive stimulus generator and result checker for a 4-bit adder with carry.
// Optional first-failure capture ports are enabled by defining ADDER_CHECK_FIRST_FAIL_EN.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   RUN   | presenting one vector per cycle, v = 0..511
//   DRAIN | no new vectors, flushing LATENCY in-flight checks
//   DONE  | sweep finished, results frozen, start begins a new sweep
module adder_stim_checker #(
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       Cin,
    input  logic [3:0] Sum,
    input  logic       Cout,
    output logic       busy,
    output logic       done,
    output logic [9:0] err_count,
`ifdef ADDER_CHECK_FIRST_FAIL_EN
    output logic       pass,
    output logic [8:0] first_fail_vec,
    output logic [4:0] first_fail_got,
    output logic       fail_seen
`else
    output logic       pass
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                      state_q, state_d;
    logic [8:0]                  v_q, v_d;
    logic [8:0]                  vec_q, vec_d;
    logic                        vld_q, vld_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        pass_q, pass_d;
    logic [9:0]                  err_q, err_d;
    logic [LATENCY-1:0]          pv_q, pv_d;
    logic [LATENCY-1:0][4:0]     pe_q, pe_d;
    logic                        mism;
`ifdef ADDER_CHECK_FIRST_FAIL_EN
    logic [LATENCY-1:0][8:0]     pn_q, pn_d;
    logic [8:0]                  ff_vec_q, ff_vec_d;
    logic [4:0]                  ff_got_q, ff_got_d;
    logic                        fs_q, fs_d;
`endif

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        vec_d   = vec_q;
        vld_d   = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q;

        // Expected result of the vector currently on the ports enters the pipeline.
        pv_d    = pv_q;
        pe_d    = pe_q;
        pv_d[0] = vld_q;
        pe_d[0] = {1'b0, vec_q[3:0]} + {1'b0, vec_q[7:4]} + {4'b0, vec_q[8]};
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
        end
`ifdef ADDER_CHECK_FIRST_FAIL_EN
        pn_d     = pn_q;
        pn_d[0]  = vec_q;
        for (int i = 1; i < LATENCY; i++) begin
            pn_d[i] = pn_q[i-1];
        end
        ff_vec_d = ff_vec_q;
        ff_got_d = ff_got_q;
        fs_d     = fs_q;
`endif

        mism = pv_q[LATENCY-1] && ({Cout, Sum} != pe_q[LATENCY-1]);
        if (mism && (err_q != 10'h3FF)) begin
            err_d = err_q + 10'd1;
        end
`ifdef ADDER_CHECK_FIRST_FAIL_EN
        if (mism && !fs_q) begin
            fs_d     = 1'b1;
            ff_vec_d = pn_q[LATENCY-1];
            ff_got_d = {Cout, Sum};
        end
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = 9'd0;
                    v_d     = 9'd1;
                    vld_d   = 1'b1;
                    err_d   = 10'd0;
`ifdef ADDER_CHECK_FIRST_FAIL_EN
                    fs_d     = 1'b0;
                    ff_vec_d = 9'd0;
                    ff_got_d = 5'd0;
`endif
                end
            end
            RUN: begin
                // v wraps to 0 once vector 511 has been put on the ports.
                if (v_q == 9'd0) begin
                    state_d = DRAIN;
                    cnt_d   = 3'(LATENCY - 1);
                end else begin
                    vec_d = v_q;
                    v_d   = v_q + 9'd1;
                    vld_d = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            v_q     <= 9'd0;
            vec_q   <= 9'd0;
            vld_q   <= 1'b0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 10'd0;
            pv_q    <= '0;
            pe_q    <= '0;
`ifdef ADDER_CHECK_FIRST_FAIL_EN
            pn_q     <= '0;
            ff_vec_q <= 9'd0;
            ff_got_q <= 5'd0;
            fs_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            vec_q   <= vec_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            pv_q    <= pv_d;
            pe_q    <= pe_d;
`ifdef ADDER_CHECK_FIRST_FAIL_EN
            pn_q     <= pn_d;
            ff_vec_q <= ff_vec_d;
            ff_got_q <= ff_got_d;
            fs_q     <= fs_d;
`endif
        end
    end

    assign A         = vec_q[3:0];
    assign B         = vec_q[7:4];
    assign Cin       = vec_q[8];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
`ifdef ADDER_CHECK_FIRST_FAIL_EN
    assign first_fail_vec = ff_vec_q;
    assign first_fail_got = ff_got_q;
    assign fail_seen      = fs_q;
`endif

endmodule

// File: tb/tb_adder_stim_checker.sv
// Directed bench: a behavioural adder with selectable faults is driven by the checker.
module tb_adder_stim_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] A, B, Sum;
    logic       Cin, Cout;
    logic       busy, done, pass;
    logic [9:0] err_count;
`ifdef ADDER_CHECK_FIRST_FAIL_EN
    logic [8:0] first_fail_vec;
    logic [4:0] first_fail_got;
    logic       fail_seen;
`endif

    int total = 0;
    int bad   = 0;
    // 0 good, 1 sum bit0 stuck at 0, 2 ignores Cin, 3 single-stage latency
    int mode  = 0;

    logic [4:0] raw, d1, d2;

    always #5 clk = ~clk;

    always_comb begin
        raw = {1'b0, A} + {1'b0, B} + ((mode == 2) ? 5'd0 : {4'd0, Cin});
        if (mode == 1) raw[0] = 1'b0;
    end

    always @(posedge clk) begin
        d1 <= raw;
        d2 <= d1;
    end

    assign {Cout, Sum} = (mode == 3) ? d1 : d2;

    adder_stim_checker #(.LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A(A), .B(B), .Cin(Cin), .Sum(Sum), .Cout(Cout),
        .busy(busy), .done(done), .err_count(err_count),
`ifdef ADDER_CHECK_FIRST_FAIL_EN
        .pass(pass),
        .first_fail_vec(first_fail_vec), .first_fail_got(first_fail_got),
        .fail_seen(fail_seen)
`else
        .pass(pass)
`endif
    );

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called just after the edge that sampled start; runs until done or a bound expires.
    task automatic run_sweep(input int restart_j, output int done_j, output int nb,
                             output int vec_bad);
        int j;
        logic [8:0] exp_v;
        j = 0; nb = 0; vec_bad = 0; done_j = -1;
        while (j < 1500) begin
            @(negedge clk);
            if (done) begin
                done_j = j;
                break;
            end
            if (busy) nb++;
            exp_v = (j < 512) ? 9'(j) : 9'd511;
            if (j < 514 && {Cin, B, A} !== exp_v) vec_bad++;
            if (j == restart_j) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            j++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        total++; if ({A, B, Cin} !== 9'd0) begin bad++; $display("FAIL reset_vec got=%h want=0", {A, B, Cin}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0 || pass !== 1'b0) begin bad++; $display("FAIL reset_done_pass got=%b%b want=00", done, pass); end
        total++; if (err_count !== 10'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_count); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_sweep();
        int dj, nb, vb;
        mode = 0;
        pulse_start();
        run_sweep(-1, dj, nb, vb);
        total++; if (dj !== 514) begin bad++; $display("FAIL good_done_time got=%0d want=514", dj); end
        total++; if (nb !== 514) begin bad++; $display("FAIL good_busy_cycles got=%0d want=514", nb); end
        total++; if (vb !== 0) begin bad++; $display("FAIL good_vec_seq bad_vectors=%0d want=0", vb); end
        total++; if (err_count !== 10'd0) begin bad++; $display("FAIL good_err got=%0d want=0", err_count); end
        total++; if (pass !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL good_pass got pass=%b busy=%b want 1 0", pass, busy); end
        repeat (3) @(negedge clk);
        total++; if (done !== 1'b1 || err_count !== 10'd0) begin bad++; $display("FAIL good_hold got done=%b err=%0d want 1 0", done, err_count); end
    endtask

    task automatic test_stuck_sum0();
        int dj, nb, vb;
        mode = 1;
        @(posedge clk); #1;
        pulse_start();
        run_sweep(-1, dj, nb, vb);
        total++; if (err_count !== 10'd256) begin bad++; $display("FAIL stuck_err got=%0d want=256", err_count); end
        total++; if (pass !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL stuck_pass got pass=%b done=%b want 0 1", pass, done); end
`ifdef ADDER_CHECK_FIRST_FAIL_EN
        total++; if (first_fail_vec !== 9'd1 || first_fail_got !== 5'd0) begin bad++; $display("FAIL stuck_first got vec=%0d got=%0d want 1 0", first_fail_vec, first_fail_got); end
        total++; if (fail_seen !== 1'b1) begin bad++; $display("FAIL stuck_seen got=%b want=1", fail_seen); end
`endif
    endtask

    task automatic test_ignore_cin();
        int dj, nb, vb;
        mode = 2;
        @(posedge clk); #1;
        pulse_start();
        run_sweep(-1, dj, nb, vb);
        total++; if (err_count !== 10'd256) begin bad++; $display("FAIL nocin_err got=%0d want=256", err_count); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL nocin_pass got=%b want=0", pass); end
`ifdef ADDER_CHECK_FIRST_FAIL_EN
        total++; if (first_fail_vec !== 9'd256) begin bad++; $display("FAIL nocin_first got=%0d want=256", first_fail_vec); end
`endif
    endtask

    task automatic test_reset_mid();
        int dj, nb, vb;
        mode = 1;
        @(posedge clk); #1;
        pulse_start();
        repeat (100) @(posedge clk);
        @(negedge clk);
        total++; if ({Cin, B, A} !== 9'd100) begin bad++; $display("FAIL mid_vec100 got=%0d want=100", {Cin, B, A}); end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++; if ({A, B, Cin, busy, done, pass} !== 12'd0 || err_count !== 10'd0) begin bad++; $display("FAIL mid_reset_outs got=%h err=%0d want 0 0", {A, B, Cin, busy, done, pass}, err_count); end
        repeat (6) @(negedge clk);
        total++; if (err_count !== 10'd0 || busy !== 1'b0) begin bad++; $display("FAIL mid_residual got err=%0d busy=%b want 0 0", err_count, busy); end
        mode = 0;
        @(posedge clk); #1;
        pulse_start();
        run_sweep(-1, dj, nb, vb);
        total++; if (pass !== 1'b1 || dj !== 514) begin bad++; $display("FAIL mid_resweep got pass=%b done_at=%0d want 1 514", pass, dj); end
    endtask

    task automatic test_restart();
        int dj, nb, vb;
        mode = 1;
        @(posedge clk); #1;
        pulse_start();
        run_sweep(200, dj, nb, vb);
        total++; if (dj !== 514 || vb !== 0) begin bad++; $display("FAIL run_start_ignored got done_at=%0d vec_bad=%0d want 514 0", dj, vb); end
        total++; if (err_count !== 10'd256) begin bad++; $display("FAIL run_start_err got=%0d want=256", err_count); end
        mode = 0;
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        total++; if (err_count !== 10'd0 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL done_restart got err=%0d busy=%b done=%b want 0 1 0", err_count, busy, done); end
        run_sweep(-1, dj, nb, vb);
        total++; if (pass !== 1'b1 || dj !== 513) begin bad++; $display("FAIL done_restart_sweep got pass=%b done_at=%0d want 1 513", pass, dj); end
    endtask

    task automatic test_latency1();
        int dj, nb, vb;
        mode = 3;
        @(posedge clk); #1;
        pulse_start();
        run_sweep(-1, dj, nb, vb);
        total++; if (err_count === 10'd0 || pass !== 1'b0) begin bad++; $display("FAIL lat1 got err=%0d pass=%b want nonzero 0", err_count, pass); end
    endtask

    initial begin
        test_reset();
        test_good_sweep();
        test_stuck_sum0();
        test_ignore_cin();
        test_reset_mid();
        test_restart();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
